fifo_tx_serializer: RTL and testbench

Drains the 8-bit, 8-deep FIFO from its read side and transmits each byte as an asynchronous serial frame (1 start bit, 8 data bits LSB first, 1 stop bit, no parity). It sits between the FIFO (`RDEN` / `empty` / `data_out`) and the board-level serial TX pin. It is the consumer end of the FIFO interface: the FIFO's writer loads bytes, and this block pops and shifts them out.

---
 rtl/fifo_tx_serializer.sv | 130 +++++++++++++
 tb/tb_fifo_tx_serializer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_tx_serializer.sv
// fifo_tx_serializer
//   Pops bytes from the read side of a FIFO and sends each one as an async
//   serial frame: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   enable       lets a new frame start (looked at only while idle)
//   fifo_empty   FIFO empty flag
//   fifo_data    FIFO read data, valid the cycle after fifo_rden
//   fifo_rden    FIFO read enable, one-cycle registered pulse per byte
//   tx           serial output, idles high
//   busy         high from POP through the last STOP cycle
//   frames_sent  completed frame count, wraps silently
module fifo_tx_serializer #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_data,
  output logic        fifo_rden,
  output logic        tx,
  output logic        busy,
  output logic [15:0] frames_sent
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [BW-1:0] baud, baud_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic [15:0]   frame_cnt, frame_cnt_nxt;
  logic          tx_nxt, busy_nxt, rden_nxt;
  logic          baud_last;

  assign baud_last   = (baud == BW'(CLKS_PER_BIT - 1));
  assign frames_sent = frame_cnt;

  // State and datapath registers. The frame counter is written every cycle
  // from its next value so the register always holds exactly what it shows.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      baud      <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      frame_cnt <= '0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      fifo_rden <= 1'b0;
    end else begin
      state     <= state_nxt;
      baud      <= baud_nxt;
      bit_idx   <= bit_nxt;
      shreg     <= shreg_nxt;
      frame_cnt <= frame_cnt_nxt;
      tx        <= tx_nxt;
      busy      <= busy_nxt;
      fifo_rden <= rden_nxt;
    end
  end

  // Next-state and datapath next values.
  always_comb begin
    state_nxt     = state;
    baud_nxt      = baud;
    bit_nxt       = bit_idx;
    shreg_nxt     = shreg;
    frame_cnt_nxt = frame_cnt;
    case (state)
      IDLE: if (enable && !fifo_empty) state_nxt = POP;
      POP:  state_nxt = LOAD;
      LOAD: begin
        shreg_nxt = fifo_data;
        baud_nxt  = '0;
        bit_nxt   = '0;
        state_nxt = START;
      end
      START: begin
        if (baud_last) begin
          baud_nxt  = '0;
          state_nxt = DATA;
        end else begin
          baud_nxt = baud + 1'b1;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_nxt = '0;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end else begin
            shreg_nxt = {1'b0, shreg[7:1]};
            bit_nxt   = bit_idx + 3'd1;
          end
        end else begin
          baud_nxt = baud + 1'b1;
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_nxt      = '0;
          frame_cnt_nxt = frame_cnt + 16'd1;
          state_nxt     = IDLE;
        end else begin
          baud_nxt = baud + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so that, once registered, they
  // line up exactly with the state the FSM is in.
  always_comb begin
    rden_nxt = (state_nxt == POP);
    busy_nxt = (state_nxt != IDLE);
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shreg_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fifo_tx_serializer.sv
module tb_fifo_tx_serializer;
  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        fifo_empty;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_rden, tx, busy;
  logic [15:0] frames_sent;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // FIFO model: writer side driven by the stimulus, reader side by fifo_rden.
  logic [7:0] mem [256];
  logic [7:0] wr_ptr = 8'd0;
  logic [7:0] rd_ptr = 8'd0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  fifo_tx_serializer #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rden(fifo_rden), .tx(tx), .busy(busy),
    .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rden) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 8'd1;
    end
  end

  // Read-pulse monitor: count pulses, log their cycle, flag any wider than 1.
  int   rden_cnt = 0;
  int   wide = 0;
  int   rden_t[$];
  logic rden_prev = 1'b0;
  always @(negedge clk) begin
    if (fifo_rden) begin
      rden_cnt <= rden_cnt + 1;
      rden_t.push_back(cyc);
      if (rden_prev) wide <= wide + 1;
    end
    rden_prev <= fifo_rden;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  // Waits (bounded) for the start bit; t0 is the cycle of its first low sample.
  task automatic wait_start(output int t0, output logic ok);
    int n = 0;
    while (tx !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    ok = (tx === 1'b0);
    t0 = cyc;
  endtask

  // Called on the first start-bit cycle; samples each bit mid-way and
  // returns on the second cycle of the stop bit.
  task automatic rx_body(output logic [7:0] b, output logic ok);
    ok = 1'b1;
    @(negedge clk);
    if (tx !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = tx;
    end
    repeat (CPB) @(negedge clk);
    if (tx !== 1'b1) ok = 1'b0;
  endtask

  task automatic recv(input string tag, input logic [7:0] exp, output int t0);
    logic ok;
    logic [7:0] b;
    wait_start(t0, ok);
    chk({tag, "_start"}, ok, 1);
    b = 8'h00;
    if (ok) rx_body(b, ok);
    chk({tag, "_frame"}, ok, 1);
    chk({tag, "_byte"}, b, exp);
  endtask

  initial begin
    int t_push, t0, t1, t2, bad;
    logic ok;

    // Reset and idle
    repeat (2) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_rden", fifo_rden, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frames", frames_sent, 0);
    rst = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || fifo_rden !== 1'b0 || busy !== 1'b0 || frames_sent !== 16'd0) bad++;
    end
    chk("idle_quiet", bad, 0);
    chk("idle_no_pop", rden_cnt, 0);

    // Single byte 0xA5
    t_push = cyc;
    push(8'hA5);
    recv("a5", 8'hA5, t0);
    chk("a5_start_lat", t0 - t_push, 3);
    chk("a5_rden_lat", rden_t[0] - t_push, 1);
    chk("a5_busy_stop", busy, 1);
    repeat (2) @(negedge clk);
    chk("a5_last_stop_busy", busy, 1);
    chk("a5_last_stop_frames", frames_sent, 0);
    @(negedge clk);
    chk("a5_done_frames", frames_sent, 1);
    chk("a5_done_busy", busy, 0);
    chk("a5_rden_cnt", rden_cnt, 1);

    // Back-to-back 0x00, 0xFF, 0x3C
    repeat (3) @(negedge clk);
    push(8'h00); push(8'hFF); push(8'h3C);
    recv("b0", 8'h00, t0);
    recv("b1", 8'hFF, t1);
    recv("b2", 8'h3C, t2);
    chk("b2b_period01", t1 - t0, 43);
    chk("b2b_period12", t2 - t1, 43);
    chk("b2b_rden01", rden_t[2] - rden_t[1], 43);
    chk("b2b_rden12", rden_t[3] - rden_t[2], 43);
    repeat (3) @(negedge clk);
    chk("b2b_frames", frames_sent, 4);
    chk("b2b_rden_cnt", rden_cnt, 4);

    // Enable gating: drop enable during DATA of the first of two bytes
    repeat (3) @(negedge clk);
    push(8'h11); push(8'h22);
    fork
      begin
        repeat (12) @(negedge clk);
        enable = 1'b0;
      end
    join_none
    recv("en1", 8'h11, t0);
    repeat (60) @(negedge clk);
    chk("en_gate_rden", rden_cnt, 5);
    chk("en_gate_busy", busy, 0);
    chk("en_gate_frames", frames_sent, 5);
    enable = 1'b1;
    recv("en2", 8'h22, t0);
    repeat (3) @(negedge clk);
    chk("en_frames", frames_sent, 6);
    chk("en_rden_cnt", rden_cnt, 6);

    // Reset during DATA bit 3
    repeat (3) @(negedge clk);
    push(8'h5A); push(8'hC3);
    wait_start(t0, ok);
    chk("rstmid_start", ok, 1);
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_tx", tx, 1);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_rden", fifo_rden, 0);
    chk("rstmid_frames", frames_sent, 0);
    rst = 1'b0;
    recv("rstmid_next", 8'hC3, t0);
    repeat (3) @(negedge clk);
    chk("rstmid_rden_cnt", rden_cnt, 8);
    chk("rstmid_frames_after", frames_sent, 1);

    // Counter wrap
    repeat (5) @(negedge clk);
    force dut.frame_cnt = 16'hFFFF;
    repeat (2) @(negedge clk);
    release dut.frame_cnt;
    @(negedge clk);
    chk("wrap_preload", frames_sent, 16'hFFFF);
    push(8'h77);
    recv("wrap", 8'h77, t0);
    repeat (3) @(negedge clk);
    chk("wrap_frames", frames_sent, 0);
    chk("rden_width", wide, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
